// File: rtl/arp_rx_parser.sv
// -----------------------------------------------------------------------------
// arp_rx_parser
//
// Receive-side ARP frame parser. It consumes the raw MAC receive byte stream
// (preamble, SFD, Ethernet header, ARP body). It accepts only ARP frames that
// are addressed to this board (broadcast or BOARD_MAC destination, TPA equal to
// BOARD_IP). For every accepted frame it publishes the sender MAC/IP and the
// operation, and raises a one-cycle completion pulse for the ARP controller.
//
// Ports
//   clk          receive clock, all logic on the rising edge
//   rstn         asynchronous active-low reset
//   rx_valid     byte strobe, high for the whole frame and low between frames
//   rx_data      received byte, preamble first
//   pc_mac       sender hardware address of the last accepted frame
//   pc_ip        sender protocol address of the last accepted frame
//   arp_rx_op    0 = request (OPER 1), 1 = reply (OPER 2) of last accepted frame
//   arp_rx_done  one-cycle pulse per accepted frame; outputs valid in that cycle
// -----------------------------------------------------------------------------
module arp_rx_parser #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [47:0] pc_mac,
  output logic [31:0] pc_ip,
  output logic        arp_rx_op,
  output logic        arp_rx_done
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_ETH_HDR  = 3'd2;
  localparam logic [2:0] S_ARP_BODY = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_WAIT_END = 3'd5;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [2:0] PRE_NEED = 3'd7;     // preamble bytes required before SFD

  // Byte indices after the SFD that drive control decisions
  localparam logic [5:0] IDX_DST_LAST = 6'd5;
  localparam logic [5:0] IDX_ETH_LAST = 6'd13;
  localparam logic [5:0] IDX_OPER_LO  = 6'd21;
  localparam logic [5:0] IDX_SHA_FIRST = 6'd22;
  localparam logic [5:0] IDX_SHA_LAST  = 6'd27;
  localparam logic [5:0] IDX_SPA_FIRST = 6'd28;
  localparam logic [5:0] IDX_SPA_LAST  = 6'd31;
  localparam logic [5:0] IDX_TPA_FIRST = 6'd38;
  localparam logic [5:0] IDX_TPA_LAST  = 6'd41;
  localparam logic [5:0] IDX_MAX       = 6'd63;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [2:0]  pre_cnt;
  logic [5:0]  byte_cnt;

  // Running destination-MAC comparisons; each stays set only while every byte
  // seen so far matches its candidate address.
  logic        dst_bcast;
  logic        dst_board;
  // Running TPA comparison over bytes 38..40; byte 41 is folded in at the end.
  logic        tpa_match;

  logic [47:0] sha_shadow;
  logic [31:0] spa_shadow;
  logic        op_shadow;

  // ---------------------------------------------------------------------------
  // Per-byte decode
  // ---------------------------------------------------------------------------
  logic        hdr_byte;     // a frame byte is being consumed in a header state
  logic        byte_ok;      // current byte satisfies the check for its index
  logic        accept;       // last TPA byte arrives and the whole frame is good
  logic [7:0]  mac_exp;      // BOARD_MAC byte expected at indices 0..4
  logic [7:0]  ip_exp;       // BOARD_IP byte expected at indices 38..40

  assign hdr_byte = rx_valid && ((state == S_ETH_HDR) || (state == S_ARP_BODY));

  // NOTE: every signal assigned in a combinational block receives a default
  // at the top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    mac_exp = 8'h00;
    ip_exp  = 8'h00;
    case (byte_cnt)
      6'd0:  mac_exp = BOARD_MAC[47:40];
      6'd1:  mac_exp = BOARD_MAC[39:32];
      6'd2:  mac_exp = BOARD_MAC[31:24];
      6'd3:  mac_exp = BOARD_MAC[23:16];
      6'd4:  mac_exp = BOARD_MAC[15:8];
      6'd38: ip_exp  = BOARD_IP[31:24];
      6'd39: ip_exp  = BOARD_IP[23:16];
      6'd40: ip_exp  = BOARD_IP[15:8];
      default: ;
    endcase
  end

  // Fixed-field checks. Indices not listed carry data or are ignored.
  always_comb begin
    byte_ok = 1'b1;
    case (byte_cnt)
      6'd5:  byte_ok = (dst_bcast && (rx_data == 8'hFF)) ||
                       (dst_board && (rx_data == BOARD_MAC[7:0]));
      6'd12: byte_ok = (rx_data == 8'h08);   // EtherType 0x0806
      6'd13: byte_ok = (rx_data == 8'h06);
      6'd14: byte_ok = (rx_data == 8'h00);   // HTYPE 0x0001
      6'd15: byte_ok = (rx_data == 8'h01);
      6'd16: byte_ok = (rx_data == 8'h08);   // PTYPE 0x0800
      6'd17: byte_ok = (rx_data == 8'h00);
      6'd18: byte_ok = (rx_data == 8'h06);   // HLEN
      6'd19: byte_ok = (rx_data == 8'h04);   // PLEN
      6'd20: byte_ok = (rx_data == 8'h00);   // OPER high byte
      6'd21: byte_ok = (rx_data == 8'h01) || (rx_data == 8'h02);
      6'd41: byte_ok = tpa_match && (rx_data == BOARD_IP[7:0]);
      default: byte_ok = 1'b1;
    endcase
  end

  assign accept = rx_valid && (state == S_ARP_BODY) &&
                  (byte_cnt == IDX_TPA_LAST) && byte_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          // Anything but a preamble byte means we joined a frame mid-way.
          state_nxt = (rx_data == PRE_BYTE) ? S_PREAMBLE : S_WAIT_END;
        end
      end

      S_PREAMBLE: begin
        if (!rx_valid) begin
          state_nxt = S_IDLE;
        end else if ((rx_data == PRE_BYTE) && (pre_cnt < PRE_NEED)) begin
          state_nxt = S_PREAMBLE;
        end else if ((rx_data == SFD_BYTE) && (pre_cnt == PRE_NEED)) begin
          state_nxt = S_ETH_HDR;
        end else begin
          // Short preamble, overlong preamble or a stray byte.
          state_nxt = S_WAIT_END;
        end
      end

      S_ETH_HDR: begin
        if (!rx_valid) begin
          state_nxt = S_IDLE;
        end else if (!byte_ok) begin
          state_nxt = S_WAIT_END;
        end else if (byte_cnt == IDX_ETH_LAST) begin
          state_nxt = S_ARP_BODY;
        end
      end

      S_ARP_BODY: begin
        if (!rx_valid) begin
          state_nxt = S_IDLE;
        end else if (!byte_ok) begin
          state_nxt = S_WAIT_END;
        end else if (byte_cnt == IDX_TPA_LAST) begin
          state_nxt = S_DONE;
        end
      end

      // DONE deliberately ignores rx_valid so a frame ending right after
      // byte 41 still completes.
      S_DONE: state_nxt = S_WAIT_END;

      // Swallow padding and FCS until the frame strobe drops.
      S_WAIT_END: begin
        if (!rx_valid) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state and datapath
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pre_cnt     <= 3'd0;
      byte_cnt    <= 6'd0;
      dst_bcast   <= 1'b0;
      dst_board   <= 1'b0;
      tpa_match   <= 1'b0;
      sha_shadow  <= 48'h0;
      spa_shadow  <= 32'h0;
      op_shadow   <= 1'b0;
      pc_mac      <= 48'h0;
      pc_ip       <= 32'h0;
      arp_rx_op   <= 1'b0;
      arp_rx_done <= 1'b0;
    end else begin
      state <= state_nxt;

      // Preamble length tracking
      if ((state == S_IDLE) && rx_valid && (rx_data == PRE_BYTE)) begin
        pre_cnt <= 3'd1;
      end else if ((state == S_PREAMBLE) && rx_valid && (rx_data == PRE_BYTE) &&
                   (pre_cnt < PRE_NEED)) begin
        pre_cnt <= pre_cnt + 3'd1;
      end

      // SFD accepted: arm the byte index and the running comparisons.
      if ((state == S_PREAMBLE) && (state_nxt == S_ETH_HDR)) begin
        byte_cnt  <= 6'd0;
        dst_bcast <= 1'b1;
        dst_board <= 1'b1;
        tpa_match <= 1'b1;
      end else if (hdr_byte) begin
        // Saturating index; it can never wrap back onto a checked field.
        if (byte_cnt != IDX_MAX) begin
          byte_cnt <= byte_cnt + 6'd1;
        end

        if (byte_cnt < IDX_DST_LAST) begin
          dst_bcast <= dst_bcast && (rx_data == 8'hFF);
          dst_board <= dst_board && (rx_data == mac_exp);
        end

        if (byte_cnt == IDX_OPER_LO) begin
          op_shadow <= (rx_data == 8'h02);
        end

        if ((byte_cnt >= IDX_SHA_FIRST) && (byte_cnt <= IDX_SHA_LAST)) begin
          sha_shadow <= {sha_shadow[39:0], rx_data};
        end

        if ((byte_cnt >= IDX_SPA_FIRST) && (byte_cnt <= IDX_SPA_LAST)) begin
          spa_shadow <= {spa_shadow[23:0], rx_data};
        end

        if ((byte_cnt >= IDX_TPA_FIRST) && (byte_cnt < IDX_TPA_LAST)) begin
          tpa_match <= tpa_match && (rx_data == ip_exp);
        end
      end

      // Publish at the edge that enters DONE so the results are already
      // stable during the single cycle in which arp_rx_done is high. All
      // shadow fields are complete by then (SPA ends at byte 31).
      arp_rx_done <= accept;
      if (accept) begin
        pc_mac    <= sha_shadow;
        pc_ip     <= spa_shadow;
        arp_rx_op <= op_shadow;
      end
    end
  end

endmodule
